joypad_controller: RTL and testbench

//  Two-port game-pad bridge between Genesis-style 3-button pads and the CPU's
//  NES-style serial joypad ports ($4016/$4017 GPIO lines of the core).

---
 rtl/joypad_controller.sv | 162 ++++++++++++++++
 tb/tb_joypad_controller.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/joypad_controller.sv
// ----------------------------------------------------------------------------
// joypad_controller
//
// Bridges two Genesis-style 3-button pads onto the CPU's NES-style serial
// joypad ports. A shared scan FSM toggles the pad select lines. It samples
// each half of the pad once per select phase and commits a full NES button
// byte at the end of every scan. Each port then serves that byte through an
// independent latch/shift register. The CPU reads it one bit per read
// strobe.
//
// Ports
//   I_clock      in   1         system clock
//   I_reset      in   1         asynchronous, active-low reset
//   I_joy_bits   in   6*ports   raw pad lines, active-low, 6 per port
//                               [0]Up [1]Down [2]Left [3]Right [4]B/A [5]C/Start
//   O_joy_mode   out  ports     pad select line per port (1 = B/C half)
//   I_GPIO_load  in   ports     strobe/latch level per port
//   I_GPIO_rden  in   ports     read strobe per port
//   O_GPIO_data  out  ports     serial button bit per port, 1 = pressed
// ----------------------------------------------------------------------------
module joypad_controller #(
    parameter int unsigned P_scan_div = 1024,
    parameter int unsigned P_ports    = 2
) (
    input  logic                   I_clock,
    input  logic                   I_reset,
    input  logic [P_ports*6-1:0]   I_joy_bits,
    output logic [P_ports-1:0]     O_joy_mode,
    input  logic [P_ports-1:0]     I_GPIO_load,
    input  logic [P_ports-1:0]     I_GPIO_rden,
    output logic [P_ports-1:0]     O_GPIO_data
);

    localparam int unsigned        L_cnt_w = (P_scan_div > 1) ? $clog2(P_scan_div) : 1;
    localparam logic [L_cnt_w-1:0] L_last  = L_cnt_w'(P_scan_div - 1);

    typedef enum logic {
        StHi = 1'b0,
        StLo = 1'b1
    } scan_state_e;

    // Synchroniser for the asynchronous pad lines (idle level is high)
    logic [P_ports*6-1:0]     r_sync1;
    logic [P_ports*6-1:0]     r_sync2;

    // Scan FSM
    scan_state_e              r_state;
    logic [L_cnt_w-1:0]       r_cnt;
    logic [P_ports-1:0]       r_joy_mode;
    // HI-phase capture per port, 1 = pressed: [0]U [1]D [2]L [3]R [4]B [5]C
    logic [P_ports-1:0][5:0]  r_hi;
    // Committed NES button byte per port
    logic [P_ports-1:0][7:0]  r_btn;

    // Serial read side
    logic [P_ports-1:0][7:0]  r_shift;
    logic [P_ports-1:0]       r_rden_q;

    logic                     w_scan_end;
    logic                     w_commit_now;
    logic [P_ports-1:0][7:0]  w_commit;
    logic [P_ports-1:0][7:0]  w_btn_fwd;

    // ------------------------------------------------------------------------
    // Pad line synchroniser
    // ------------------------------------------------------------------------
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
        end else begin
            r_sync1 <= I_joy_bits;
            r_sync2 <= r_sync1;
        end
    end

    assign w_scan_end   = (r_cnt == L_last);
    assign w_commit_now = (r_state == StLo) && w_scan_end;

    // Full NES byte assembled from the held HI capture plus the live LO lines.
    // NES order: [0]A(pad C) [1]B [2]Select(pad A) [3]Start [4]U [5]D [6]L [7]R
    always_comb begin
        w_commit = '0;
        for (int p = 0; p < int'(P_ports); p++) begin
            w_commit[p] = {r_hi[p][3], r_hi[p][2], r_hi[p][1], r_hi[p][0],
                           ~r_sync2[p*6+5], ~r_sync2[p*6+4],
                           r_hi[p][4], r_hi[p][5]};
        end
    end

    // Forward the byte being committed this cycle so a concurrent reload
    // never picks up the stale value.
    always_comb begin
        w_btn_fwd = r_btn;
        if (w_commit_now) begin
            w_btn_fwd = w_commit;
        end
    end

    // ------------------------------------------------------------------------
    // Scan FSM: HI phase samples directions + B/C, LO phase samples A/Start
    // and commits. Left/Right are never taken from the LO phase because the
    // pad pulls them low there for identification.
    // ------------------------------------------------------------------------
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            r_state    <= StHi;
            r_cnt      <= '0;
            r_joy_mode <= '1;
            r_hi       <= '0;
            r_btn      <= '0;
        end else if (w_scan_end) begin
            r_cnt <= '0;
            unique case (r_state)
                StHi: begin
                    for (int p = 0; p < int'(P_ports); p++) begin
                        r_hi[p] <= ~r_sync2[p*6 +: 6];
                    end
                    r_state    <= StLo;
                    r_joy_mode <= '0;
                end
                StLo: begin
                    r_btn      <= w_commit;
                    r_state    <= StHi;
                    r_joy_mode <= '1;
                end
            endcase
        end else begin
            r_cnt <= r_cnt + L_cnt_w'(1);
        end
    end

    assign O_joy_mode = r_joy_mode;

    // ------------------------------------------------------------------------
    // Per-port latch/shift register. A falling read strobe advances one bit;
    // ones are shifted in so reads past the eighth return 1.
    // ------------------------------------------------------------------------
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            r_shift  <= '0;
            r_rden_q <= '0;
        end else begin
            r_rden_q <= I_GPIO_rden;
            for (int p = 0; p < int'(P_ports); p++) begin
                if (I_GPIO_load[p]) begin
                    r_shift[p] <= w_btn_fwd[p];
                end else if (r_rden_q[p] && !I_GPIO_rden[p]) begin
                    r_shift[p] <= {1'b1, r_shift[p][7:1]};
                end
            end
        end
    end

    always_comb begin
        O_GPIO_data = '0;
        for (int p = 0; p < int'(P_ports); p++) begin
            O_GPIO_data[p] = r_shift[p][0];
        end
    end

endmodule

// File: tb/tb_joypad_controller.sv
// ----------------------------------------------------------------------------
// tb_joypad_controller
//
// Drives two behavioural Genesis pads (button sets, mux on the select line)
// and checks the serial NES bit stream against the button byte packed from
// those sets.
// ----------------------------------------------------------------------------
module tb_joypad_controller;

    localparam int unsigned P = 64;

    typedef struct packed {
        logic up;
        logic down;
        logic left;
        logic right;
        logic btn_a;
        logic btn_b;
        logic btn_c;
        logic start;
    } pad_t;

    logic        clk;
    logic        rst_n;
    logic [11:0] joy_bits;
    logic [1:0]  joy_mode;
    logic [1:0]  load;
    logic [1:0]  rden;
    logic [1:0]  gdata;

    pad_t        pads [2];

    int          n_tests = 0;
    int          n_fail  = 0;

    joypad_controller #(
        .P_scan_div (P),
        .P_ports    (2)
    ) u_dut (
        .I_clock     (clk),
        .I_reset     (rst_n),
        .I_joy_bits  (joy_bits),
        .O_joy_mode  (joy_mode),
        .I_GPIO_load (load),
        .I_GPIO_rden (rden),
        .O_GPIO_data (gdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 3-button pad: active-low lines, half chosen by select.
    always_comb begin
        joy_bits = '1;
        for (int p = 0; p < 2; p++) begin
            joy_bits[p*6+0] = ~pads[p].up;
            joy_bits[p*6+1] = ~pads[p].down;
            if (joy_mode[p]) begin
                joy_bits[p*6+2] = ~pads[p].left;
                joy_bits[p*6+3] = ~pads[p].right;
                joy_bits[p*6+4] = ~pads[p].btn_b;
                joy_bits[p*6+5] = ~pads[p].btn_c;
            end else begin
                joy_bits[p*6+2] = 1'b0;
                joy_bits[p*6+3] = 1'b0;
                joy_bits[p*6+4] = ~pads[p].btn_a;
                joy_bits[p*6+5] = ~pads[p].start;
            end
        end
    end

    // NES order: A(pad C), B, Select(pad A), Start, Up, Down, Left, Right
    function automatic logic [7:0] nes_byte(input pad_t pd);
        return {pd.right, pd.left, pd.down, pd.up, pd.start, pd.btn_a, pd.btn_b, pd.btn_c};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait for the select line to return high, i.e. a byte commit.
    task automatic wait_commit();
        logic [1:0] prev;
        bit         seen;
        prev = joy_mode;
        seen = 1'b0;
        for (int i = 0; i < 3 * int'(P) && !seen; i++) begin
            @(posedge clk);
            #1;
            if (prev == 2'b00 && joy_mode == 2'b11) seen = 1'b1;
            prev = joy_mode;
        end
        if (!seen) check("commit_timeout", 8'd0, 8'd1);
    endtask

    task automatic strobe(input logic [1:0] mask);
        @(negedge clk);
        load = mask;
        @(negedge clk);
        @(negedge clk);
        load = 2'b00;
        @(negedge clk);
    endtask

    task automatic read_bit(input int p, output logic b);
        @(negedge clk);
        rden[p] = 1'b1;
        @(negedge clk);
        b = gdata[p];
        rden[p] = 1'b0;
        @(negedge clk);
    endtask

    task automatic read_check(input string tag, input int p, input logic [7:0] exp_byte,
                              input int n);
        logic b;
        for (int i = 0; i < n; i++) begin
            read_bit(p, b);
            check(tag, {7'd0, b}, {7'd0, (i < 8) ? exp_byte[i] : 1'b1});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       b;
        logic [7:0] exp_b [2];
        int         idx   [2];
        int         p;

        rst_n = 1'b0;
        load  = 2'b00;
        rden  = 2'b00;
        pads[0] = '0;
        pads[1] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_mode", {6'd0, joy_mode}, 8'h03);
        check("rst_data", {6'd0, gdata}, 8'h00);

        // Select timing after reset release
        @(negedge clk);
        rst_n = 1'b1;
        repeat (P - 1) @(posedge clk);
        #1 check("mode_hi_end", {6'd0, joy_mode}, 8'h03);
        @(posedge clk);
        #1 check("mode_lo", {6'd0, joy_mode}, 8'h00);
        repeat (P - 1) @(posedge clk);
        #1 check("mode_lo_end", {6'd0, joy_mode}, 8'h00);
        @(posedge clk);
        #1 check("mode_back_hi", {6'd0, joy_mode}, 8'h03);

        // Idle pads: 8 zeros then ones
        strobe(2'b11);
        read_check("idle_p0", 0, 8'h00, 9);

        // Port0: Up + C pressed
        pads[0] = '0;
        pads[0].up = 1'b1;
        pads[0].btn_c = 1'b1;
        wait_commit();
        wait_commit();
        strobe(2'b11);
        read_check("p0_upc", 0, 8'h11, 8);
        read_check("p0_upc_p1", 1, 8'h00, 8);

        // Port1: Start + A pressed, port0 idle
        pads[0] = '0;
        pads[1] = '0;
        pads[1].start = 1'b1;
        pads[1].btn_a = 1'b1;
        wait_commit();
        wait_commit();
        strobe(2'b11);
        read_check("p1_starta", 1, 8'h0C, 8);
        read_check("p1_starta_p0", 0, 8'h00, 8);

        // Load held high: read strobes must not shift
        pads[0] = '0;
        pads[0].btn_c = 1'b1;
        pads[0].down = 1'b1;
        pads[1] = '0;
        wait_commit();
        wait_commit();
        @(negedge clk);
        load = 2'b01;
        for (int i = 0; i < 3; i++) begin
            read_bit(0, b);
            check("load_hold", {7'd0, b}, 8'h01);
        end
        load = 2'b00;
        read_check("load_release", 0, nes_byte(pads[0]), 8);

        // Commit during load: reload must take the new byte on that same edge
        pads[0] = '0;
        wait_commit();
        wait_commit();
        @(negedge clk);
        load = 2'b01;
        wait_commit();
        pads[0].btn_c = 1'b1;
        wait_commit();
        check("commit_forward", {7'd0, gdata[0]}, 8'h01);
        load = 2'b00;

        // Randomised pads with interleaved reads on both ports
        for (int it = 0; it < 10; it++) begin
            pads[0] = pad_t'(8'($urandom));
            pads[1] = pad_t'(8'($urandom));
            wait_commit();
            wait_commit();
            strobe(2'b11);
            exp_b[0] = nes_byte(pads[0]);
            exp_b[1] = nes_byte(pads[1]);
            idx[0] = 0;
            idx[1] = 0;
            for (int k = 0; k < 20; k++) begin
                p = int'($urandom_range(1, 0));
                read_bit(p, b);
                check("rand_read", {7'd0, b},
                      {7'd0, (idx[p] < 8) ? exp_b[p][idx[p]] : 1'b1});
                idx[p]++;
            end
        end

        // Reset in the middle of a shift sequence
        pads[0] = pad_t'(8'hFF);
        wait_commit();
        wait_commit();
        strobe(2'b01);
        read_check("pre_reset", 0, 8'hFF, 3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", {6'd0, gdata}, 8'h00);
        check("midrst_mode", {6'd0, joy_mode}, 8'h03);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        strobe(2'b01);
        read_check("post_reset", 0, 8'h00, 8);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
